// File: rtl/spi_time_receiver.sv
// rtl/spi_time_receiver.sv - SPI time-set receiver with local 1 Hz timekeeping for the clock face
module spi_time_receiver #(
  parameter int          CLK_HZ      = 40_000_000,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       sclk,
  input  logic       sdi,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [5:0] hour,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       synced
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  logic          sclk_meta, sclk_sync, sclk_prev;
  logic          sdi_meta, sdi_sync;
  logic [31:0]   shift_q;
  logic [4:0]    bitcnt;
  logic [IW-1:0] idle;
  logic          check_pend;
  logic [PW-1:0] presc;
  logic [4:0]    hh;
  logic [5:0]    mm, ss;

  logic          rise, timeout, frame_valid, load, presc_wrap;
  logic [7:0]    f_hdr, f_hh, f_mm, f_ss;
  logic [4:0]    hh12;
  logic [5:0]    hour_calc;

  assign rise       = sclk_sync & ~sclk_prev;
  // Fires once, on the cycle the idle counter would step onto its saturation value.
  assign timeout    = !rise && (idle == IDLE_LAST);
  assign f_hdr      = shift_q[31:24];
  assign f_hh       = shift_q[23:16];
  assign f_mm       = shift_q[15:8];
  assign f_ss       = shift_q[7:0];
  assign frame_valid = (f_hdr == SYNC_BYTE) && (f_hh <= 8'd23) &&
                       (f_mm <= 8'd59) && (f_ss <= 8'd59);
  assign load       = check_pend && frame_valid;
  assign presc_wrap = (presc == PRESC_MAX);
  assign hh12       = (hh >= 5'd12) ? hh - 5'd12 : hh;
  assign hour_calc  = 6'(hh12) * 6'd5 + mm / 6'd12;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      sdi_meta  <= 1'b0;
      sdi_sync  <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      sdi_meta  <= sdi;
      sdi_sync  <= sdi_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      shift_q    <= '0;
      bitcnt     <= '0;
      idle       <= '0;
      check_pend <= 1'b0;
    end else begin
      check_pend <= rise && (bitcnt == 5'd31);
      if (rise) begin
        shift_q <= {shift_q[30:0], sdi_sync};
        bitcnt  <= bitcnt + 5'd1;
        idle    <= '0;
      end else begin
        if (idle != IDLE_MAX) idle <= idle + 1'b1;
        if (timeout) bitcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      synced    <= 1'b0;
    end else begin
      frame_ok  <= load;
      frame_err <= (check_pend && !frame_valid) || (timeout && bitcnt != 5'd0);
      if (load) synced <= 1'b1;
    end
  end

  // A load on the same cycle as a prescaler wrap swallows the increment.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      presc <= '0;
      hh    <= '0;
      mm    <= '0;
      ss    <= '0;
    end else if (load) begin
      presc <= '0;
      hh    <= f_hh[4:0];
      mm    <= f_mm[5:0];
      ss    <= f_ss[5:0];
    end else if (presc_wrap) begin
      presc <= '0;
      if (ss == 6'd59) begin
        ss <= '0;
        if (mm == 6'd59) begin
          mm <= '0;
          hh <= (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        end else begin
          mm <= mm + 6'd1;
        end
      end else begin
        ss <= ss + 6'd1;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      second <= '0;
      minute <= '0;
      hour   <= '0;
    end else begin
      second <= ss;
      minute <= mm;
      hour   <= hour_calc;
    end
  end

endmodule

// File: tb/tb_spi_time_receiver.sv
// tb/tb_spi_time_receiver.sv - self-checking bench for spi_time_receiver
module tb_spi_time_receiver;

  localparam int CLK_HZ = 100;

  logic       clk = 1'b0;
  logic       reset_b, sclk, sdi;
  logic [5:0] second, minute, hour;
  logic       frame_ok, frame_err, synced;

  spi_time_receiver #(.CLK_HZ(CLK_HZ), .TIMEOUT_CYC(64), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_b(reset_b), .sclk(sclk), .sdi(sdi),
    .second(second), .minute(minute), .hour(hour),
    .frame_ok(frame_ok), .frame_err(frame_err), .synced(synced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hdr, hh, mm, ss;
    bit         ok;
    int         e_sec, e_min, e_hour;
  } vec_t;

  typedef struct {
    int kind;   // 1 = frame_ok, 2 = frame_err
    int t;      // loaded time in seconds of day
    bit lat;    // check last-rise-to-pulse latency
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[7];
  int   checks = 0, failures = 0;
  int   cyc = 0, c0 = 0, base = 0, last_rise = 0;
  bit   exp_synced = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model(input string name);
    int t, h, m, s;
    t = (base + (cyc - c0 - 1) / CLK_HZ) % 86400;
    s = t % 60;
    m = (t / 60) % 60;
    h = t / 3600;
    chk({name, "_second"}, int'(second), s);
    chk({name, "_minute"}, int'(minute), m);
    chk({name, "_hour"}, int'(hour), (h % 12) * 5 + m / 12);
    chk({name, "_synced"}, int'(synced), int'(exp_synced));
  endtask

  // Scoreboard: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (reset_b && (frame_ok || frame_err)) begin
      chk("pulse_exclusive", int'(frame_ok && frame_err), 0);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", int'(frame_ok) * 1 + int'(frame_err) * 2, 0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("pulse_kind", frame_ok ? 1 : 2, e.kind);
        if (e.lat) chk("pulse_latency", cyc - last_rise, 4);
        if (e.kind == 1 && frame_ok) begin
          base = e.t;
          c0   = cyc;
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    sdi  = b;
    sclk = 1'b0;
    repeat (4) @(posedge clk);
    #1 sclk = 1'b1;
    last_rise = cyc;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // aligned=1 places the last rise so the load lands on a prescaler wrap.
  task automatic send_frame(input logic [31:0] w, input int kind, input int t, input bit aligned);
    sb_t e;
    int  m, target;
    e.kind = kind; e.t = t; e.lat = 1'b1;
    sbq.push_back(e);
    for (int i = 31; i >= 1; i--) send_bit(w[i]);
    if (!aligned) begin
      send_bit(w[0]);
    end else begin
      sdi  = w[0];
      sclk = 1'b0;
      m = (cyc + 8 - c0 + CLK_HZ - 1) / CLK_HZ;
      target = c0 + CLK_HZ * m - 4;
      while (cyc < target) begin
        @(posedge clk);
        #1;
      end
      sclk = 1'b1;
      last_rise = cyc;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sb(input int max_cyc);
    for (int i = 0; i < max_cyc && sbq.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic wait_until_j(input int j);
    while (cyc < c0 + j) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'h0E, 8'h1E, 8'h2D, 1'b1, 45, 30, 12};
    vecs[1] = '{8'h5A, 8'h01, 8'h01, 8'h01, 1'b0,  0,  0,  0};
    vecs[2] = '{8'hA5, 8'h05, 8'h3C, 8'h00, 1'b0,  0,  0,  0};
    vecs[3] = '{8'hA5, 8'h18, 8'h00, 8'h00, 1'b0,  0,  0,  0};
    vecs[4] = '{8'hA5, 8'h00, 8'h00, 8'h3C, 1'b0,  0,  0,  0};
    vecs[5] = '{8'hA5, 8'h0C, 8'h00, 8'h00, 1'b1,  0,  0,  0};
    vecs[6] = '{8'hA5, 8'h0B, 8'h3B, 8'h00, 1'b1,  0, 59, 59};

    reset_b = 1'b0; sclk = 1'b0; sdi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_second", int'(second), 0);
    chk("rst_minute", int'(minute), 0);
    chk("rst_hour", int'(hour), 0);
    chk("rst_ok", int'(frame_ok), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_synced", int'(synced), 0);
    @(posedge clk);
    #1 reset_b = 1'b1;
    c0 = cyc; base = 0;

    // Reset in the middle of a frame: discarded silently.
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    sclk = 1'b0;
    reset_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_second", int'(second), 0);
    chk("midrst_minute", int'(minute), 0);
    chk("midrst_hour", int'(hour), 0);
    chk("midrst_synced", int'(synced), 0);
    reset_b = 1'b1;
    c0 = cyc; base = 0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    check_model("after_midrst");

    for (int v = 0; v < 7; v++) begin
      send_frame({vecs[v].hdr, vecs[v].hh, vecs[v].mm, vecs[v].ss}, vecs[v].ok ? 1 : 2,
                 int'(vecs[v].hh) * 3600 + int'(vecs[v].mm) * 60 + int'(vecs[v].ss), 1'b0);
      wait_sb(20);
      if (vecs[v].ok) exp_synced = 1'b1;
      @(negedge clk);
      if (vecs[v].ok) begin
        chk($sformatf("vec%0d_second", v), int'(second), vecs[v].e_sec);
        chk($sformatf("vec%0d_minute", v), int'(minute), vecs[v].e_min);
        chk($sformatf("vec%0d_hour", v), int'(hour), vecs[v].e_hour);
      end
      check_model($sformatf("vec%0d", v));
    end

    // 23:59:59 rolls over to midnight.
    send_frame(32'hA5_17_3B_3B, 1, 86399, 1'b0);
    wait_sb(20);
    wait_until_j(100);
    chk("roll_pre_second", int'(second), 59);
    chk("roll_pre_hour", int'(hour), 59);
    @(negedge clk);
    chk("roll_second", int'(second), 0);
    chk("roll_minute", int'(minute), 0);
    chk("roll_hour", int'(hour), 0);

    // Partial frame aborted by the idle timeout, then a clean frame.
    begin
      sb_t e;
      logic [31:0] w;
      e.kind = 2; e.t = 0; e.lat = 1'b0;
      sbq.push_back(e);
      w = 32'hA5_0F_00_00;
      for (int i = 31; i >= 20; i--) send_bit(w[i]);
      wait_sb(100);
    end
    send_frame(32'hA5_01_02_03, 1, 3723, 1'b0);
    wait_sb(20);
    @(negedge clk);
    chk("after_to_second", int'(second), 3);
    chk("after_to_minute", int'(minute), 2);
    chk("after_to_hour", int'(hour), 5);

    // Load coinciding with a prescaler wrap: no extra second.
    send_frame(32'hA5_08_14_1E, 1, 8 * 3600 + 20 * 60 + 30, 1'b1);
    wait_sb(20);
    @(negedge clk);
    chk("wrap_second", int'(second), 30);
    chk("wrap_minute", int'(minute), 20);
    chk("wrap_hour", int'(hour), 41);
    wait_until_j(100);
    chk("wrap_hold_second", int'(second), 30);
    @(negedge clk);
    chk("wrap_next_second", int'(second), 31);
    check_model("wrap_model");

    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
